// File: rtl/mul_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_arb_ctrl
// Purpose  : Round-robin arbiter and sequencer that shares one repeated-
//            addition multiplier datapath (A reg, P accumulator, B down-
//            counter, B==0 flag) among NREQ requesters. One request is
//            accepted at a time. Its operands are latched and then driven
//            onto the shared bus. The product is returned through a
//            valid/ready response.
// Ports    : clk, rst_n            - clock, async active-low reset
//            req/opa/opb/gnt       - requester side (gnt is a 1-cycle pulse)
//            busy                  - an operation is in flight
//            lda/ldb/ldp/clrp/decb - datapath strobes
//            bus                   - operand bus to the A/B load inputs
//            eqz, p_in             - datapath status and P value
//            rsp_vld/rsp_rdy/rsp_id/rsp_data - response handshake
// Revision : 1.0 - initial release
// ============================================================================
module mul_arb_ctrl #(
    parameter  int NREQ = 2,
    parameter  int W    = 16,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   opa,
    input  logic [NREQ*W-1:0]   opb,
    output logic [NREQ-1:0]     gnt,
    output logic                busy,
    output logic                lda,
    output logic                ldb,
    output logic                ldp,
    output logic                clrp,
    output logic                decb,
    output logic [W-1:0]        bus,
    input  logic                eqz,
    input  logic [W-1:0]        p_in,
    output logic                rsp_vld,
    input  logic                rsp_rdy,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_ACC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_ptr;

    logic             w_any;
    logic [IDW-1:0]   w_sel;

    // Round-robin pick: scan offsets from the highest down so that the
    // requester closest to the pointer (offset 0 first) is the last writer.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                w_any = 1'b1;
                w_sel = IDW'(idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture, response registers and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= '0;
            r_ptr    <= '0;
            rsp_vld  <= 1'b0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_a  <= opa[w_sel*W +: W];
                r_b  <= opb[w_sel*W +: W];
                r_id <= w_sel;
            end
            // P already holds the final sum when the counter reads zero.
            if (r_state == S_ACC && eqz) begin
                rsp_vld  <= 1'b1;
                rsp_data <= p_in;
                rsp_id   <= r_id;
            end
            if (r_state == S_DONE && rsp_rdy) begin
                rsp_vld <= 1'b0;
                r_ptr   <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

    // Next state and datapath strobes, decoded from the state (plus eqz)
    always_comb begin
        w_next = r_state;
        gnt    = '0;
        lda    = 1'b0;
        ldb    = 1'b0;
        ldp    = 1'b0;
        clrp   = 1'b0;
        decb   = 1'b0;
        bus    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    gnt[w_sel] = 1'b1;
                    w_next     = S_LDA;
                end
            end
            S_LDA: begin
                lda    = 1'b1;
                bus    = r_a;
                w_next = S_LDB;
            end
            S_LDB: begin
                ldb    = 1'b1;
                clrp   = 1'b1;
                bus    = r_b;
                w_next = S_ACC;
            end
            S_ACC: begin
                if (!eqz) begin
                    ldp  = 1'b1;
                    decb = 1'b1;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_rdy) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_arb_ctrl
// Purpose  : Self-checking bench for mul_arb_ctrl with a behavioural
//            multiplier datapath. Expected responses go into a scoreboard
//            queue when a grant is seen. A monitor pops them on each response
//            handshake and checks data, id, latency and strobe timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_arb_ctrl;

    localparam int NREQ = 2;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] opa = '0;
    logic [NREQ*W-1:0] opb = '0;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              lda, ldb, ldp, clrp, decb;
    logic [W-1:0]      bus;
    logic              eqz;
    logic [W-1:0]      p_in;
    logic              rsp_vld;
    logic              rsp_rdy = 1'b1;
    logic [0:0]        rsp_id;
    logic [W-1:0]      rsp_data;

    mul_arb_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .opa(opa), .opb(opb),
        .gnt(gnt), .busy(busy), .lda(lda), .ldb(ldb), .ldp(ldp),
        .clrp(clrp), .decb(decb), .bus(bus), .eqz(eqz), .p_in(p_in),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id),
        .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    // Behavioural repeated-addition datapath
    logic [W-1:0] dp_a = '0, dp_b = '0, dp_p = '0;
    always @(posedge clk) begin
        if (lda) dp_a <= bus;
        if (ldb) dp_b <= bus;
        else if (decb) dp_b <= dp_b - 1'b1;
        if (clrp) dp_p <= '0;
        else if (ldp) dp_p <= dp_p + dp_a;
    end
    assign eqz  = (dp_b == '0);
    assign p_in = dp_p;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           g;
        int           b;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called right at a negedge after req is driven; returns at negedge+2
    // of the grant cycle and pushes the expected response.
    task automatic wait_gnt(input int exp_id, input int a, input int b);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 1000 && !got; n++) begin
            #2;
            if (gnt != '0) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            chk("gnt_timeout", 32'd0, 32'd1);
        end else begin
            chk("gnt_onehot", 32'(gnt), 32'(1 << exp_id));
            sb.push_back('{exp_id, W'(a * b), cyc, b});
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 2000 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic single_op(input int id, input int a, input int b);
        @(negedge clk);
        req[id] = 1'b1;
        opa[id*W +: W] = W'(a);
        opb[id*W +: W] = W'(b);
        wait_gnt(id, a, b);
        @(negedge clk);
        req[id] = 1'b0;
        // Operands changing after the grant must not disturb the operation
        opa[id*W +: W] = 16'hDEAD;
        opb[id*W +: W] = 16'h0BEE;
    endtask

    // Monitor: pops the scoreboard on each response handshake
    bit prev_vld = 1'b0;
    int rise_cyc = 0, ldp_cnt = 0, lda_cyc = 0, ldb_cyc = 0;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (gnt != '0) ldp_cnt = 0;
            if (ldp) ldp_cnt++;
            if (lda) lda_cyc = cyc;
            if (ldb) begin
                ldb_cyc = cyc;
                chk("clrp_with_ldb", 32'(clrp), 32'd1);
            end
            if (lda && ldb) chk("lda_ldb_excl", 32'd1, 32'd0);
            if (rsp_vld && !prev_vld) rise_cyc = cyc;
            if (rsp_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                    chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                    if (rsp_rdy) begin
                        chk("latency", 32'(rise_cyc - sb[0].g), 32'(sb[0].b + 4));
                        chk("ldp_cycles", 32'(ldp_cnt), 32'(sb[0].b));
                        chk("lda_cycle", 32'(lda_cyc - sb[0].g), 32'd1);
                        chk("ldb_cycle", 32'(ldb_cyc - sb[0].g), 32'd2);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_vld = rsp_vld;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, checked without any clock edge having occurred
        #3;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", 32'({lda, ldb, ldp, clrp, decb}), 32'd0);
        chk("rst_vld", 32'(rsp_vld), 32'd0);
        chk("rst_bus", 32'(bus), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        single_op(0, 3, 4);          // 12
        drain();
        single_op(0, 7, 0);          // B=0 -> 0, one ACC cycle
        drain();
        single_op(0, 0, 5);          // A=0 -> 0
        drain();
        single_op(1, 300, 300);      // wraps to 24464, pointer ends at 0
        drain();

        // Two requesters held together: served 0,1,0,1
        @(negedge clk);
        opa[0*W +: W] = 16'd2; opb[0*W +: W] = 16'd3;
        opa[1*W +: W] = 16'd4; opb[1*W +: W] = 16'd5;
        req = 2'b11;
        wait_gnt(0, 2, 3);
        @(negedge clk);
        wait_gnt(1, 4, 5);
        @(negedge clk);
        wait_gnt(0, 2, 3);
        @(negedge clk);
        wait_gnt(1, 4, 5);
        @(negedge clk);
        req = 2'b00;
        drain();

        // Response back-pressure for five DONE cycles
        rsp_rdy = 1'b0;
        single_op(0, 5, 6);          // 30
        for (int n = 0; n < 100 && !rsp_vld; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            chk("stall_vld", 32'(rsp_vld), 32'd1);
            chk("stall_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_vld", 32'(rsp_vld), 32'd0);
        drain();

        // Reset during ACC (pointer is 1 beforehand)
        single_op(1, 9, 9);
        repeat (4) @(negedge clk);
        chk("pre_rst_in_acc", 32'(ldp), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_strobes", 32'({lda, ldb, ldp, clrp, decb}), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_vld", 32'(rsp_vld), 32'd0);
        chk("midrst_bus", 32'(bus), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // First arbitration after reset favours requester 0
        opa[0*W +: W] = 16'd1; opb[0*W +: W] = 16'd1;
        opa[1*W +: W] = 16'd2; opb[1*W +: W] = 16'd2;
        req = 2'b11;
        wait_gnt(0, 1, 1);
        @(negedge clk);
        req[0] = 1'b0;
        wait_gnt(1, 2, 2);           // 4
        @(negedge clk);
        req[1] = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
